// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection for the 5-stage RV32I core.
// A load-use dependency turns the EX slot into a one-cycle bubble and freezes PC and IF/ID.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic [2:0]      id_func3,
  input  logic            id_func7_b30,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_mem_to_reg,
  input  logic            id_alu_src,
  input  logic            id_branch,
  input  logic [1:0]      id_alu_op,
  input  logic            flush,
  input  logic            hold,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_func3,
  output logic            ex_func7_b30,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            ex_alu_src,
  output logic            ex_branch,
  output logic [1:0]      ex_alu_op,
  output logic            load_use_stall,
  output logic            pc_write,
  output logic            if_id_write
);

  logic hazard;
  logic rs1Match;
  logic rs2Match;
  logic bubble;
  logic loadCtrl;

  // x0 is never a real destination, so a load into x0 can't create a dependency.
  always_comb begin
    rs1Match = id_uses_rs1 & (id_rs1 == ex_rd);
    rs2Match = id_uses_rs2 & (id_rs2 == ex_rd);
    hazard   = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) & (rs1Match | rs2Match);
  end

  // A flush kills the dependent instruction anyway, so it suppresses the stall and
  // lets the redirect PC load.
  assign load_use_stall = hazard & ~flush;
  assign pc_write       = ~hold & ~load_use_stall;
  assign if_id_write    = ~hold & ~load_use_stall;

  assign bubble   = flush | load_use_stall;
  assign loadCtrl = id_valid & ~bubble;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_rs1_data   <= '0;
      ex_rs2_data   <= '0;
      ex_imm        <= '0;
      ex_rs1        <= 5'd0;
      ex_rs2        <= 5'd0;
      ex_rd         <= 5'd0;
      ex_func3      <= 3'd0;
      ex_func7_b30  <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_branch     <= 1'b0;
      ex_alu_op     <= 2'b00;
    end else if (!hold) begin
      // Data and indices always follow ID; only valid and controls decide whether
      // EX holds a real instruction or a bubble.
      ex_pc         <= id_pc;
      ex_rs1_data   <= id_rs1_data;
      ex_rs2_data   <= id_rs2_data;
      ex_imm        <= id_imm;
      ex_rs1        <= id_rs1;
      ex_rs2        <= id_rs2;
      ex_rd         <= id_rd;
      ex_func3      <= id_func3;
      ex_func7_b30  <= id_func7_b30;
      ex_valid      <= loadCtrl;
      ex_reg_write  <= loadCtrl & id_reg_write;
      ex_mem_read   <= loadCtrl & id_mem_read;
      ex_mem_write  <= loadCtrl & id_mem_write;
      ex_mem_to_reg <= loadCtrl & id_mem_to_reg;
      ex_alu_src    <= loadCtrl & id_alu_src;
      ex_branch     <= loadCtrl & id_branch;
      ex_alu_op     <= loadCtrl ? id_alu_op : 2'b00;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: an instruction-level model of the EX slot checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        f7;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        as;
    logic        br;
    logic [1:0]  aop;
  } ex_t;

  // controls packed as {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch}
  localparam logic [5:0] C_ALU   = 6'b100000;
  localparam logic [5:0] C_LOAD  = 6'b110110;
  localparam logic [5:0] C_STORE = 6'b001010;
  localparam logic [155:0] CTRL_MASK = {1'b1, 147'd0, 8'hff};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic [2:0]  id_func3;
  logic        id_func7_b30;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch;
  logic [1:0]  id_alu_op;
  logic        flush, hold;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_func3;
  logic        ex_func7_b30;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch;
  logic [1:0]  ex_alu_op;
  logic        load_use_stall, pc_write, if_id_write;

  int n_cmp = 0;
  int n_bad = 0;
  logic check_en = 1'b0;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_func3(id_func3),
    .id_func7_b30(id_func7_b30), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src),
    .id_branch(id_branch), .id_alu_op(id_alu_op), .flush(flush), .hold(hold),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_func3(ex_func3),
    .ex_func7_b30(ex_func7_b30), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src),
    .ex_branch(ex_branch), .ex_alu_op(ex_alu_op), .load_use_stall(load_use_stall),
    .pc_write(pc_write), .if_id_write(if_id_write)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- model: the EX slot as an instruction record ----------------
  ex_t  m;
  logic m_known;   // data fields are don't-care after a bubble
  logic [155:0] dut_b;

  assign dut_b = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
                  ex_func3, ex_func7_b30, ex_reg_write, ex_mem_read, ex_mem_write,
                  ex_mem_to_reg, ex_alu_src, ex_branch, ex_alu_op};

  // A real load in EX writing a non-zero register that the real ID instruction reads.
  function automatic logic model_stall();
    logic reads_it;
    reads_it = (id_uses_rs1 && id_rs1 == m.rd) || (id_uses_rs2 && id_rs2 == m.rd);
    return id_valid && m.valid && m.mr && (m.rd != 0) && reads_it && !flush;
  endfunction

  always @(posedge clk or negedge rst) begin
    ex_t nx;
    if (!rst) begin
      m       <= '0;
      m_known <= 1'b1;
    end else if (!hold) begin
      nx      = '0;
      nx.pc   = id_pc;
      nx.rs1d = id_rs1_data;
      nx.rs2d = id_rs2_data;
      nx.imm  = id_imm;
      nx.rs1  = id_rs1;
      nx.rs2  = id_rs2;
      nx.rd   = id_rd;
      nx.f3   = id_func3;
      nx.f7   = id_func7_b30;
      if (flush || model_stall()) begin
        m_known <= 1'b0;
      end else begin
        m_known <= 1'b1;
        if (id_valid) begin
          nx.valid = 1'b1;
          {nx.rw, nx.mr, nx.mw, nx.m2r, nx.as, nx.br} =
            {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch};
          nx.aop = id_alu_op;
        end
      end
      m <= nx;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      logic exp_lus;
      exp_lus = model_stall();
      if (m_known) chk("ex_bundle", dut_b, m);
      else         chk("ex_ctrl", dut_b & CTRL_MASK, m & CTRL_MASK);
      chk("load_use_stall", load_use_stall, exp_lus);
      chk("pc_write", pc_write, !hold && !exp_lus);
      chk("if_id_write", if_id_write, !hold && !exp_lus);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic put_instr(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                           input logic u2, input logic [5:0] ctrl, input logic [1:0] aop);
    id_valid     = v;
    id_pc        = pc;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_rd        = rd;
    id_uses_rs1  = u1;
    id_uses_rs2  = u2;
    {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch} = ctrl;
    id_alu_op    = aop;
    id_rs1_data  = $urandom;
    id_rs2_data  = $urandom;
    id_imm       = $urandom;
    id_func3     = 3'($urandom_range(0, 7));
    id_func7_b30 = 1'($urandom_range(0, 1));
  endtask

  task automatic pedge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    flush = 1'b0;
    hold  = 1'b0;
    put_instr(1'b1, 32'h1234, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, C_LOAD, 2'b00);

    // Reset with arbitrary inputs
    @(posedge clk);
    check_en = 1'b1;
    @(negedge clk);
    chk("reset ex_valid", ex_valid, 0);
    chk("reset ex_pc", ex_pc, 0);
    chk("reset ex_mem_read", ex_mem_read, 0);
    chk("reset stall", load_use_stall, 0);
    chk("reset pc_write", pc_write, 1);
    chk("reset if_id_write", if_id_write, 1);
    pedge();
    rst = 1'b1;

    // Pass-through
    put_instr(1'b1, 32'h40, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, C_ALU, 2'b10);
    pedge();
    chk("pass ex_pc", ex_pc, 32'h40);
    chk("pass ex_rd", ex_rd, 5);
    chk("pass ex_reg_write", ex_reg_write, 1);
    chk("pass ex_valid", ex_valid, 1);
    chk("pass ex_alu_op", ex_alu_op, 2'b10);

    // Load-use: lw x5 then add x6,x5,x7
    put_instr(1'b1, 32'h44, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, C_LOAD, 2'b00);
    pedge();
    put_instr(1'b1, 32'h48, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, C_ALU, 2'b10);
    #1;
    chk("lu stall", load_use_stall, 1);
    chk("lu pc_write", pc_write, 0);
    chk("lu if_id_write", if_id_write, 0);
    pedge();
    chk("lu bubble valid", ex_valid, 0);
    chk("lu bubble ctrl", {ex_reg_write, ex_mem_read, ex_mem_to_reg, ex_alu_src, ex_alu_op}, 0);
    chk("lu after stall", load_use_stall, 0);
    chk("lu after pc_write", pc_write, 1);
    pedge();
    chk("lu add valid", ex_valid, 1);
    chk("lu add rs1", ex_rs1, 5);
    chk("lu add pc", ex_pc, 32'h48);

    // Load to x0 never stalls
    put_instr(1'b1, 32'h50, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, C_LOAD, 2'b00);
    pedge();
    put_instr(1'b1, 32'h54, 5'd0, 5'd1, 5'd6, 1'b1, 1'b1, C_ALU, 2'b10);
    #1;
    chk("x0 no stall", load_use_stall, 0);

    // rs2 matches but not read
    put_instr(1'b1, 32'h58, 5'd1, 5'd0, 5'd9, 1'b1, 1'b0, C_LOAD, 2'b00);
    pedge();
    put_instr(1'b1, 32'h5c, 5'd3, 5'd9, 5'd6, 1'b1, 1'b0, C_ALU, 2'b00);
    #1;
    chk("unused rs2 no stall", load_use_stall, 0);

    // Store data depends on load
    put_instr(1'b1, 32'h60, 5'd1, 5'd0, 5'd9, 1'b1, 1'b0, C_LOAD, 2'b00);
    pedge();
    put_instr(1'b1, 32'h64, 5'd2, 5'd9, 5'd0, 1'b1, 1'b1, C_STORE, 2'b00);
    #1;
    chk("store rs2 stall", load_use_stall, 1);
    pedge();
    chk("store bubble mem_write", ex_mem_write, 0);
    pedge();
    chk("store issued mem_write", ex_mem_write, 1);

    // rd equals both rs1 and rs2: single bubble
    put_instr(1'b1, 32'h68, 5'd1, 5'd0, 5'd4, 1'b1, 1'b0, C_LOAD, 2'b00);
    pedge();
    put_instr(1'b1, 32'h6c, 5'd4, 5'd4, 5'd7, 1'b1, 1'b1, C_ALU, 2'b10);
    #1;
    chk("dual stall", load_use_stall, 1);
    pedge();
    chk("dual single bubble", load_use_stall, 0);
    pedge();
    chk("dual issued pc", ex_pc, 32'h6c);

    // Flush together with a hazard
    put_instr(1'b1, 32'h70, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LOAD, 2'b00);
    pedge();
    put_instr(1'b1, 32'h74, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, C_ALU, 2'b10);
    flush = 1'b1;
    #1;
    chk("flush stall", load_use_stall, 0);
    chk("flush pc_write", pc_write, 1);
    pedge();
    chk("flush ex_valid", ex_valid, 0);
    flush = 1'b0;

    // Hold for 3 cycles, flush held through the end of hold
    put_instr(1'b1, 32'h80, 5'd1, 5'd0, 5'd8, 1'b1, 1'b0, C_LOAD, 2'b00);
    pedge();
    hold = 1'b1;
    put_instr(1'b1, 32'h84, 5'd8, 5'd0, 5'd6, 1'b1, 1'b0, C_ALU, 2'b10);
    #1;
    chk("hold1 pc_write", pc_write, 0);
    pedge();
    chk("hold1 ex_pc", ex_pc, 32'h80);
    put_instr(1'b1, 32'h88, 5'd2, 5'd3, 5'd6, 1'b1, 1'b1, C_ALU, 2'b10);
    flush = 1'b1;
    #1;
    chk("hold2 pc_write", pc_write, 0);
    pedge();
    chk("hold2 ex_pc", ex_pc, 32'h80);
    put_instr(1'b1, 32'h8c, 5'd2, 5'd3, 5'd6, 1'b1, 1'b1, C_STORE, 2'b00);
    pedge();
    chk("hold3 ex_pc", ex_pc, 32'h80);
    chk("hold3 ex_mem_read", ex_mem_read, 1);
    hold = 1'b0;
    #1;
    chk("hold release pc_write", pc_write, 1);
    pedge();
    chk("hold release bubble", ex_valid, 0);
    flush = 1'b0;

    // Reset asserted mid-stall
    put_instr(1'b1, 32'h90, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, C_LOAD, 2'b00);
    pedge();
    put_instr(1'b1, 32'h94, 5'd3, 5'd0, 5'd6, 1'b1, 1'b0, C_ALU, 2'b10);
    #1;
    chk("pre-reset stall", load_use_stall, 1);
    rst = 1'b0;
    #1;
    chk("mid reset ex_valid", ex_valid, 0);
    chk("mid reset stall", load_use_stall, 0);
    chk("mid reset pc_write", pc_write, 1);
    pedge();
    rst = 1'b1;
    pedge();
    chk("post reset valid", ex_valid, 1);
    chk("post reset pc", ex_pc, 32'h94);

    // Mixed vectors over a small register set, checked by the model
    for (int i = 0; i < 60; i++) begin
      put_instr(1'($urandom_range(0, 3) != 0), 32'h100 + 32'(i * 4),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                (i % 2 == 0) ? C_LOAD : 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)));
      flush = ($urandom_range(0, 5) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      pedge();
    end
    flush = 1'b0;
    hold  = 1'b0;
    @(negedge clk);
    check_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
